// File: rtl/bcd_6d_to_binary_20b_seq_if.sv
// Purpose: request/result bundle between a digit-entry source and the BCD-to-binary converter.
// Latency: none, wiring only.
// Backpressure: the source must respect busy; start is ignored while a conversion runs.
interface bcd_6d_to_binary_20b_seq_if #(
  parameter int N = 20,
  parameter int M = 24
);
  logic         start;
  logic [M-1:0] input_6d;
  logic [N-1:0] output_20b;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start,
    output input_6d,
    input  output_20b,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  input_6d,
    output output_20b,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/bcd_6d_to_binary_20b_seq.sv
// Purpose: packed 6-digit BCD to 20-bit binary via reverse double-dabble, one bit per cycle.
// Latency: start at edge k -> busy for N cycles -> done pulse in cycle k+N+1 (k+1 on bad digit).
// Backpressure: start is only accepted in IDLE or DONE; while busy=1 it is dropped.
module bcd_6d_to_binary_20b_seq #(
  parameter int N = 20,
  parameter int M = 24
) (
  input logic                    clk,
  input logic                    rst,
  bcd_6d_to_binary_20b_seq_if.slave io
);

  localparam int D  = M / 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  bcd_reg, bcd_nxt;
  logic [N-1:0]  bin_reg, bin_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  out_reg, out_nxt;
  logic          err_reg, err_nxt;

  logic          accept;
  logic          bad_digit;
  logic [M+N-1:0] shifted;
  logic [M-1:0]  bcd_adj;

  // A new request is taken whenever no conversion is in flight.
  assign accept = io.start && (state != CONV);

  // Flag any input digit outside 0..9.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (io.input_6d[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then correct every digit that reached 8 or more.
  always_comb begin
    shifted = {bcd_reg, bin_reg} >> 1;
    bcd_adj = shifted[M+N-1:N];
    for (int i = 0; i < D; i++) begin
      if (shifted[N + 4*i +: 4] >= 4'd8) bcd_adj[4*i +: 4] = shifted[N + 4*i +: 4] - 4'd3;
    end
  end

  // Next-state and datapath updates; everything holds unless the current state says otherwise.
  always_comb begin
    state_nxt = state;
    bcd_nxt   = bcd_reg;
    bin_nxt   = bin_reg;
    cnt_nxt   = cnt;
    out_nxt   = out_reg;
    err_nxt   = err_reg;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept) begin
          if (bad_digit) begin
            out_nxt   = '0;
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            bcd_nxt   = io.input_6d;
            bin_nxt   = '0;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            state_nxt = CONV;
          end
        end
      end
      CONV: begin
        bcd_nxt = bcd_adj;
        bin_nxt = shifted[N-1:0];
        cnt_nxt = cnt + CW'(1);
        // The last shift lands the complete binary value; publish it together with done.
        if (cnt == CW'(N - 1)) begin
          out_nxt   = shifted[N-1:0];
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      out_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      state   <= state_nxt;
      bcd_reg <= bcd_nxt;
      bin_reg <= bin_nxt;
      cnt     <= cnt_nxt;
      out_reg <= out_nxt;
      err_reg <= err_nxt;
    end
  end

  assign io.busy       = (state == CONV);
  assign io.done       = (state == DONE);
  assign io.output_20b = out_reg;
  assign io.err        = err_reg;

endmodule

// File: tb/tb_bcd_6d_to_binary_20b_seq.sv
// Purpose: directed checks of the sequential BCD-to-binary converter against a result scoreboard.
// Latency: checks done timing, busy length and result hold relative to each accepted start.
// Backpressure: exercises start while busy, reset mid-conversion and start held high.
module tb_bcd_6d_to_binary_20b_seq;

  logic clk;
  logic rst;

  bcd_6d_to_binary_20b_seq_if #(.N(20), .M(24)) bus ();

  bcd_6d_to_binary_20b_seq #(.N(20), .M(24)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // {err, output_20b} expected for each accepted request, oldest first.
  logic [20:0] sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; the request is sampled at the next rising edge.
  task automatic launch(input logic [23:0] bcd, input logic [19:0] exp_out, input logic exp_err);
    sb_q.push_back({exp_err, exp_out});
    bus.start    = 1'b1;
    bus.input_6d = bcd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait for done (bounded), then check timing, busy length, result stability and the result.
  task automatic expect_done(input string tag, input int exp_lat, input int exp_busy);
    int          n      = 0;
    int          nbusy  = 0;
    logic        stable = 1'b1;
    logic [19:0] held;
    logic [20:0] e;
    held = bus.output_20b;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) begin
        nbusy++;
        if (bus.output_20b !== held) stable = 1'b0;
      end
    end while (!bus.done && n < 60);
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " out_stable"}, 32'(stable), 32'd1);
    check({tag, " sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " output_20b"}, 32'(bus.output_20b), 32'(e[19:0]));
      check({tag, " err"}, 32'(bus.err), 32'(e[20]));
    end
  endtask

  initial begin
    int dn;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.input_6d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset output_20b", 32'(bus.output_20b), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic conversion, then result must hold after done drops.
    launch(24'h123456, 20'h1E240, 1'b0);
    expect_done("t1", 21, 20);
    @(negedge clk);
    check("t1 hold output", 32'(bus.output_20b), 32'h1E240);
    check("t1 done pulse width", 32'(bus.done), 32'd0);

    // Extremes.
    launch(24'h999999, 20'hF423F, 1'b0);
    expect_done("t2 max", 21, 20);
    launch(24'h000000, 20'h00000, 1'b0);
    expect_done("t2 zero", 21, 20);
    launch(24'h054321, 20'h0D431, 1'b0);
    expect_done("t2 mid", 21, 20);

    // Invalid digits: immediate done with err, no busy.
    launch(24'h12A456, 20'h00000, 1'b1);
    expect_done("t3 bad", 1, 0);
    launch(24'hF00000, 20'h00000, 1'b1);
    expect_done("t3 bad_msd", 1, 0);

    // Start while busy is ignored; err from the previous request is cleared.
    launch(24'h123456, 20'h1E240, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.start    = 1'b1;
    bus.input_6d = 24'h000001;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    expect_done("t4 ignore", 16, 15);

    // Reset mid-conversion aborts with no done pulse.
    launch(24'h999999, 20'hF423F, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("t5 busy after rst", 32'(bus.busy), 32'd0);
    check("t5 done after rst", 32'(bus.done), 32'd0);
    check("t5 output after rst", 32'(bus.output_20b), 32'd0);
    check("t5 err after rst", 32'(bus.err), 32'd0);
    dn = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("t5 no done pulse", 32'(dn), 32'd0);
    launch(24'h000042, 20'h0002A, 1'b0);
    expect_done("t5 after", 21, 20);

    // Start held high: back-to-back conversions, input switched in the done cycle.
    sb_q.push_back({1'b0, 20'h0000A});
    bus.start    = 1'b1;
    bus.input_6d = 24'h000010;
    @(posedge clk);
    #1;
    expect_done("t6 first", 21, 20);
    sb_q.push_back({1'b0, 20'h00063});
    bus.input_6d = 24'h000099;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    expect_done("t6 second", 21, 20);
    check("t6 sb drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
